sar_logic: RTL and testbench

Successive-approximation controller that generates the `dac_state` bus consumed by the capacitor driver. It also generates the `dac_diffcaps` mode bit. It sequences sample, compare and decide phases, and drives a strobe/valid handshake with the comparator. Trial codes go to the capacitor array MSB-first, one bit per comparator decision, and the final code is presented on `result` with a one-cycle `done` pulse. The block sits between the comparator and the capacitor driver inside the ADC core.

---
 rtl/sar_pkg.sv | 20 ++
 rtl/sar_wait_timer.sv | 30 +++
 rtl/sar_logic.sv | 138 +++++++++++++
 tb/tb_sar_logic.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR conversion controller.
package sar_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_COMPARE,
    S_WAIT,
    S_DONE
  } sar_state_t;

  localparam int NDAC_DEF          = 16;
  localparam int SAMPLE_CYCLES_DEF = 2;
  localparam int WAIT_TIMEOUT_DEF  = 15;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sar_wait_timer.sv
// Loadable down-counter shared by the sample hold and comparator timeout.
module sar_wait_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/sar_logic.sv
// SAR controller: sample, per-bit compare/decide, result hand-off.
module sar_logic
  import sar_pkg::*;
#(
  parameter int Ndac          = NDAC_DEF,
  parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF,
  parameter int WAIT_TIMEOUT  = WAIT_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            diffcaps_cfg,
  input  logic            comp_out,
  input  logic            comp_valid,
  output logic            sample,
  output logic            comp_start,
  output logic [Ndac-1:0] dac_state,
  output logic            dac_diffcaps,
  output logic            busy,
  output logic            done,
  output logic [Ndac-1:0] result,
  output logic            timeout_err
);

  localparam int PW   = ptr_w(Ndac);
  localparam int TMAX = (SAMPLE_CYCLES > WAIT_TIMEOUT) ?
                        SAMPLE_CYCLES : WAIT_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [Ndac-1:0] MSB_ONLY = {1'b1, {(Ndac-1){1'b0}}};

  sar_state_t    state;
  logic [PW-1:0] ptr;
  logic          tmr_clr;
  logic          tmr_load;
  logic          tmr_dec;
  logic          tmr_exp;
  logic [TW-1:0] tmr_val;
  logic          decide;
  logic          bit_now;

  // Counter holds N-1 so the phase ends on the Nth cycle it was loaded for.
  always_comb begin
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    unique case (1'b1)
      (state == S_IDLE): begin
        tmr_clr  = !start;
        tmr_load = start;
        tmr_val  = TW'(SAMPLE_CYCLES - 1);
      end
      (state == S_COMPARE): begin
        tmr_load = 1'b1;
        tmr_val  = TW'(WAIT_TIMEOUT - 1);
      end
      (state == S_SAMPLE),
      (state == S_WAIT): tmr_dec = 1'b1;
      default: ;
    endcase
  end

  sar_wait_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  assign decide  = (state == S_WAIT) && (comp_valid || tmr_exp);
  assign bit_now = comp_valid & comp_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ptr          <= PW'(Ndac - 1);
      sample       <= 1'b0;
      comp_start   <= 1'b0;
      dac_state    <= '0;
      dac_diffcaps <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      timeout_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_SAMPLE;
            busy         <= 1'b1;
            sample       <= 1'b1;
            dac_state    <= MSB_ONLY;
            dac_diffcaps <= diffcaps_cfg;
            timeout_err  <= 1'b0;
            ptr          <= PW'(Ndac - 1);
          end
        end
        S_SAMPLE: begin
          if (tmr_exp) begin
            sample     <= 1'b0;
            comp_start <= 1'b1;
            state      <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          comp_start <= 1'b0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (decide) begin
            dac_state[ptr] <= bit_now;
            if (!comp_valid) timeout_err <= 1'b1;
            if (ptr != '0) begin
              dac_state[ptr - 1'b1] <= 1'b1;
              ptr        <= ptr - 1'b1;
              comp_start <= 1'b1;
              state      <= S_COMPARE;
            end else begin
              result <= {dac_state[Ndac-1:1], bit_now};
              done   <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_logic.sv
// Scoreboarded bench for sar_logic with a behavioural comparator.
module tb_sar_logic;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        diffcaps_cfg;
  logic        comp_out;
  logic        comp_valid;
  logic        sample;
  logic        comp_start;
  logic [15:0] dac_state;
  logic        dac_diffcaps;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        timeout_err;

  sar_logic dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .diffcaps_cfg (diffcaps_cfg),
    .comp_out     (comp_out),
    .comp_valid   (comp_valid),
    .sample       (sample),
    .comp_start   (comp_start),
    .dac_state    (dac_state),
    .dac_diffcaps (dac_diffcaps),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // comparator model
  logic [15:0] vin;
  int          cmode;
  int          dly;
  bit          glitch;
  bit          supp_first;
  bit          force_v;
  int          trial_idx;
  int          cnt;
  logic [15:0] trials[$];

  function automatic logic model_bit();
    case (cmode)
      1:       return 1'b1;
      2:       return 1'b0;
      default: return vin >= dac_state;
    endcase
  endfunction

  initial begin
    comp_valid = 1'b0;
    comp_out   = 1'b0;
    cnt        = 0;
    forever begin
      @(negedge clk);
      comp_valid = 1'b0;
      comp_out   = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !(supp_first && trial_idx == 1)) begin
          comp_valid = 1'b1;
          comp_out   = model_bit();
        end
      end
      if (rst_n && comp_start) begin
        trials.push_back(dac_state);
        trial_idx++;
        cnt = dly;
        if (glitch) begin
          comp_valid = 1'b1;
          comp_out   = !model_bit();
        end
      end
      if (force_v) begin
        comp_valid = 1'b1;
        comp_out   = 1'b1;
      end
      if (!rst_n) cnt = 0;
    end
  end

  // scoreboard
  typedef struct {
    logic [15:0] res;
    logic        terr;
    int          when;
  } exp_t;

  exp_t sb[$];
  int   done_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done result=%0h", result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", 64'(result), 64'(e.res));
          chk("timeout_err", 64'(timeout_err), 64'(e.terr));
          chk("done_cycle", 64'(cyc), 64'(e.when));
        end
      end
    end
  end

  // called at a negedge with the DUT in IDLE; returns one cycle later
  task automatic begin_conv(input logic [15:0] v, input int m,
                            input int d, input bit g, input bit s,
                            input logic [15:0] r, input logic te,
                            input int lat, input bit hold);
    vin        = v;
    cmode      = m;
    dly        = d;
    glitch     = g;
    supp_first = s;
    trial_idx  = 0;
    trials.delete();
    start      = 1'b1;
    sb.push_back('{res: r, terr: te, when: cyc + lat});
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // returns at the negedge of the cycle in which done is high
  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (done) break;
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_wait expired after %0d cycles", budget);
      sb.delete();
    end
  endtask

  typedef struct {
    logic [15:0] vin;
    int          mode;
    int          dly;
    bit          glitch;
    bit          supp;
    logic [15:0] res;
    logic        terr;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{16'hA5C3, 0, 1, 1'b0, 1'b0, 16'hA5C3, 1'b0, 35};
    vecs[1] = '{16'h0000, 1, 1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 35};
    vecs[2] = '{16'hFFFF, 2, 1, 1'b0, 1'b0, 16'h0000, 1'b0, 35};
    vecs[3] = '{16'hFFFF, 0, 1, 1'b0, 1'b1, 16'h7FFF, 1'b1, 49};
    vecs[4] = '{16'h3C3C, 0, 1, 1'b0, 1'b0, 16'h3C3C, 1'b0, 35};
    vecs[5] = '{16'h5A5A, 0, 1, 1'b1, 1'b0, 16'h5A5A, 1'b0, 35};
    vecs[6] = '{16'h0F0F, 0, 5, 1'b0, 1'b0, 16'h0F0F, 1'b0, 99};
    vecs[7] = '{16'h0001, 0, 1, 1'b0, 1'b0, 16'h0001, 1'b0, 35};

    rst_n        = 1'b0;
    start        = 1'b0;
    diffcaps_cfg = 1'b0;
    vin          = '0;
    cmode        = 0;
    dly          = 1;
    glitch       = 1'b0;
    supp_first   = 1'b0;
    force_v      = 1'b0;
    trial_idx    = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({sample, comp_start, dac_diffcaps, busy,
                         done, timeout_err}), 0);
    chk("rst_dac", 64'(dac_state), 0);
    chk("rst_result", 64'(result), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      begin_conv(vecs[i].vin, vecs[i].mode, vecs[i].dly,
                 vecs[i].glitch, vecs[i].supp, vecs[i].res,
                 vecs[i].terr, vecs[i].lat, 1'b0);
      if (i == 0) begin
        chk("sample_t1", 64'(sample), 1);
        chk("busy_t1", 64'(busy), 1);
        @(negedge clk);
        chk("sample_t2", 64'(sample), 1);
        @(negedge clk);
        chk("sample_t3", 64'(sample), 0);
        chk("comp_start_t3", 64'(comp_start), 1);
      end
      if (i == 4) chk("terr_cleared", 64'(timeout_err), 0);
      wait_done(150);
      if (i == 0 && trials.size() >= 3) begin
        chk("trial0", 64'(trials[0]), 64'h8000);
        chk("trial1", 64'(trials[1]), 64'hC000);
        chk("trial2", 64'(trials[2]), 64'hA000);
      end
      if (i == 3) chk("terr_at_done", 64'(timeout_err), 1);
      @(negedge clk);
    end

    // comp_valid in IDLE must not start or alter anything
    force_v = 1'b1;
    repeat (4) @(negedge clk);
    force_v = 1'b0;
    chk("idle_valid_busy", 64'(busy), 0);
    chk("idle_valid_dac", 64'(dac_state), 64'h0001);

    // start pulse and diffcaps toggle mid-conversion
    begin
      int n;
      diffcaps_cfg = 1'b1;
      begin_conv(16'h1357, 0, 1, 1'b0, 1'b0, 16'h1357, 1'b0, 35, 1'b0);
      repeat (10) @(negedge clk);
      start        = 1'b1;
      diffcaps_cfg = 1'b0;
      @(negedge clk);
      start = 1'b0;
      wait_done(150);
      chk("diffcaps_latched", 64'(dac_diffcaps), 1);
      @(negedge clk);
      n = done_cnt;
      repeat (40) @(negedge clk);
      chk("no_requeue_done", 64'(done_cnt), 64'(n));
      chk("no_requeue_busy", 64'(busy), 0);
      chk("diffcaps_hold", 64'(dac_diffcaps), 1);
      chk("dac_hold", 64'(dac_state), 64'h1357);
    end

    // start held high: one IDLE cycle between conversions
    begin_conv(16'h2468, 0, 1, 1'b0, 1'b0, 16'h2468, 1'b0, 35, 1'b1);
    wait_done(150);
    @(negedge clk);
    chk("held_idle_gap", 64'(sample), 0);
    sb.push_back('{res: 16'h2468, terr: 1'b0, when: cyc + 35});
    @(negedge clk);
    chk("held_resample", 64'(sample), 1);
    chk("held_diffcaps", 64'(dac_diffcaps), 0);
    start = 1'b0;
    wait_done(150);
    @(negedge clk);

    // reset at the 10th bit
    diffcaps_cfg = 1'b1;
    begin_conv(16'hA5C3, 0, 1, 1'b0, 1'b0, 16'hA5C3, 1'b0, 35, 1'b0);
    for (int i = 0; i < 100 && trial_idx < 10; i++) @(negedge clk);
    chk("reached_bit9", 64'(trial_idx), 10);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", 64'({sample, comp_start, dac_diffcaps, busy,
                               done, timeout_err}), 0);
    chk("async_rst_dac", 64'(dac_state), 0);
    chk("async_rst_result", 64'(result), 0);
    sb.delete();
    @(negedge clk);
    rst_n        = 1'b1;
    diffcaps_cfg = 1'b0;
    @(negedge clk);
    begin_conv(16'h1234, 0, 1, 1'b0, 1'b0, 16'h1234, 1'b0, 35, 1'b0);
    wait_done(150);
    @(negedge clk);

    chk("sb_drained", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
